// File: rtl/fir_pkg.sv
// Shared definitions for the sample-path FIR filters: widths, the 9-tap
// symmetric low-pass prototype, and the interpolator state encoding.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 36;
  localparam int NTAPS  = 9;

  localparam logic signed [COEF_W-1:0] H [NTAPS] = '{
    16'sh04F6, 16'sh0AE4, 16'sh1089, 16'sh1496, 16'sh160F,
    16'sh1496, 16'sh1089, 16'sh0AE4, 16'sh04F6
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    SUM  = 3'd2,
    OUT0 = 3'd3,
    OUT1 = 3'd4
  } fir_state_e;

endpackage

// File: rtl/fir_sat.sv
// Arithmetic right shift (truncating toward minus infinity) followed by
// saturation from the accumulator width down to the sample width.
module fir_sat #(
  parameter int IN_W  = 36,
  parameter int OUT_W = 16,
  parameter int SHIFT = 14
) (
  input  logic [IN_W-1:0]  acc_i,
  output logic [OUT_W-1:0] sat_o
);

  logic signed [IN_W-1:0] shifted;
  logic [IN_W-OUT_W:0]    top;

  assign shifted = $signed(acc_i) >>> SHIFT;
  // The value fits when every bit from the output sign bit upward agrees.
  assign top = shifted[IN_W-1:OUT_W-1];

  always_comb begin
    if ((&top) || (~|top)) begin
      sat_o = shifted[OUT_W-1:0];
    end else if (top[IN_W-OUT_W]) begin
      sat_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_interp2.sv
// Two-times interpolating polyphase FIR: one input sample in, the even-branch
// then odd-branch filtered samples out, through valid/ready handshakes.
module fir_interp2
  import fir_pkg::*;
#(
  parameter int SHIFT = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              inReady,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady,
  output logic [2:0]        dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and data hold steady until that edge.
  fir_state_e               state_q;
  logic signed [DATA_W-1:0] x_q  [5];
  logic signed [PROD_W-1:0] pe_q [5];
  logic signed [PROD_W-1:0] po_q [4];
  logic [ACC_W-1:0]         acc0_d;
  logic [ACC_W-1:0]         acc1_d;
  logic [ACC_W-1:0]         acc1_q;
  logic [DATA_W-1:0]        sat0;
  logic [DATA_W-1:0]        sat1;
  logic [DATA_W-1:0]        out_data_q;
  logic                     out_valid_q;
  logic                     accept;

  assign inReady     = (state_q == IDLE) || ((state_q == OUT1) && outReady);
  assign accept      = inValid && inReady;
  assign outData     = out_data_q;
  assign outValid    = out_valid_q;
  assign dbg_state_o = state_q;

  always_comb begin
    acc0_d = '0;
    acc1_d = '0;
    for (int k = 0; k < 5; k++) begin
      acc0_d = acc0_d + {{(ACC_W-PROD_W){pe_q[k][PROD_W-1]}}, pe_q[k]};
    end
    for (int k = 0; k < 4; k++) begin
      acc1_d = acc1_d + {{(ACC_W-PROD_W){po_q[k][PROD_W-1]}}, po_q[k]};
    end
  end

  // Branch 0 is saturated straight off the adder so its register is outData
  // itself, which puts the first output in OUT0 right after SUM.
  fir_sat #(.IN_W(ACC_W), .OUT_W(DATA_W), .SHIFT(SHIFT)) u_sat0 (
    .acc_i (acc0_d),
    .sat_o (sat0)
  );

  fir_sat #(.IN_W(ACC_W), .OUT_W(DATA_W), .SHIFT(SHIFT)) u_sat1 (
    .acc_i (acc1_q),
    .sat_o (sat1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc1_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        x_q[k]  <= '0;
        pe_q[k] <= '0;
      end
      for (int k = 0; k < 4; k++) begin
        po_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        x_q[0] <= inData;
        for (int k = 1; k < 5; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= MUL;
        end
        MUL: begin
          for (int k = 0; k < 5; k++) begin
            pe_q[k] <= PROD_W'(x_q[k]) * PROD_W'(H[2*k]);
          end
          for (int k = 0; k < 4; k++) begin
            po_q[k] <= PROD_W'(x_q[k]) * PROD_W'(H[2*k+1]);
          end
          state_q <= SUM;
        end
        SUM: begin
          acc1_q      <= acc1_d;
          out_data_q  <= sat0;
          out_valid_q <= 1'b1;
          state_q     <= OUT0;
        end
        OUT0: begin
          if (outReady) begin
            out_data_q <= sat1;
            state_q    <= OUT1;
          end
        end
        OUT1: begin
          if (outReady) begin
            out_valid_q <= 1'b0;
            state_q     <= inValid ? MUL : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: impulse, full-scale saturation, backpressure,
// back-to-back throughput and mid-flight reset.
module tb_fir_interp2;

  logic        clk;
  logic        rst_n;
  logic [15:0] inData;
  logic        inValid;
  logic        inReady;
  logic [15:0] outData;
  logic        outValid;
  logic        outReady;
  logic [2:0]  dbg_state;

  int checks;
  int errors;
  logic        sb_en;
  logic [15:0] exp_q[$];
  logic [15:0] imp_seq [10];

  fir_interp2 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inData      (inData),
    .inValid     (inValid),
    .inReady     (inReady),
    .outData     (outData),
    .outValid    (outValid),
    .outReady    (outReady),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every transferred output is matched against the expected queue
  always @(negedge clk) begin
    if (rst_n && sb_en && outValid && outReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got %h with no expected output", outData);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (outData !== e) begin
          errors++;
          $display("FAIL sb_data got %h exp %h", outData, e);
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    inValid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] s);
    int n;
    inData  = s;
    inValid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!inReady) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inReady got %b exp 1", inReady);
    end
    @(posedge clk);
    #1 inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_left got %0d outputs missing exp 0", exp_q.size());
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((dbg_state != 3'd0 || outValid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (dbg_state != 3'd0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout state got %0d exp 0", dbg_state);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_impulse();
    for (int i = 0; i < 10; i++) exp_q.push_back(imp_seq[i]);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks += 4;
    if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
    if (outData !== 16'h0000) begin errors++; $display("FAIL reset_outData got %h exp 0000", outData); end
    if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b exp 1", inReady); end
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_impulse();
    outReady = 1'b1;
    sb_en = 1'b1;
    push_impulse();
    repeat (4) exp_q.push_back(16'h0000);
    send(16'h4000);
    repeat (6) send(16'h0000);
    drain();
  endtask

  task automatic test_back_to_back();
    logic exp_ir;
    logic exp_ov;
    do_reset();
    sb_en = 1'b1;
    outReady = 1'b1;
    push_impulse();
    inData = 16'h4000;
    inValid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_ir = ((c % 4) == 0);
      exp_ov = (c >= 3) && (((c % 4) == 3) || ((c % 4) == 0));
      checks += 2;
      if (inReady !== exp_ir) begin
        errors++;
        $display("FAIL b2b_inReady cycle %0d got %b exp %b", c, inReady, exp_ir);
      end
      if (outValid !== exp_ov) begin
        errors++;
        $display("FAIL b2b_outValid cycle %0d got %b exp %b", c, outValid, exp_ov);
      end
      @(posedge clk);
      #1;
      if (c == 0) inData = 16'h0000;
      if (c == 19) inValid = 1'b0;
    end
    drain();
  endtask

  task automatic test_full_scale(input logic [15:0] s, input logic [15:0] e0,
                                 input logic [15:0] e1);
    outReady = 1'b1;
    sb_en = 1'b0;
    repeat (4) send(s);
    wait_idle();
    sb_en = 1'b1;
    repeat (4) begin
      exp_q.push_back(e0);
      exp_q.push_back(e1);
    end
    repeat (4) send(s);
    drain();
  endtask

  task automatic test_reset_midflight();
    outReady = 1'b1;
    sb_en = 1'b0;
    send(16'h1234);
    @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL mid_state got %0d exp 2", dbg_state);
    end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (outValid !== 1'b0) begin errors++; $display("FAIL mid_outValid got %b exp 0", outValid); end
    if (outData !== 16'h0000) begin errors++; $display("FAIL mid_outData got %h exp 0000", outData); end
    if (inReady !== 1'b1) begin errors++; $display("FAIL mid_inReady got %b exp 1", inReady); end
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_en = 1'b1;
    push_impulse();
    send(16'h4000);
    repeat (4) send(16'h0000);
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    sb_en = 1'b1;
    outReady = 1'b0;
    push_impulse();
    send(16'h4000);
    n = 0;
    @(negedge clk);
    while (!outValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (outValid !== 1'b1) begin errors++; $display("FAIL bp_outValid cycle %0d got %b exp 1", i, outValid); end
      if (outData !== 16'h04F6) begin errors++; $display("FAIL bp_outData cycle %0d got %h exp 04f6", i, outData); end
      if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady cycle %0d got %b exp 0", i, inReady); end
      @(negedge clk);
    end
    @(posedge clk);
    #1 outReady = 1'b1;
    repeat (4) send(16'h0000);
    drain();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sb_en    = 1'b0;
    rst_n    = 1'b0;
    inData   = '0;
    inValid  = 1'b0;
    outReady = 1'b0;
    imp_seq  = '{16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
                 16'h1496, 16'h1089, 16'h0AE4, 16'h04F6, 16'h0000};
    test_reset();
    test_impulse();
    test_back_to_back();
    test_full_scale(16'h7FFF, 16'h7FFF, 16'h7DE7);
    test_reset_midflight();
    test_full_scale(16'h8000, 16'h8000, 16'h8218);
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_interp2.md
# fir_interp2

Two-times interpolating polyphase FIR for the transmit/reconstruction side of the sample path. It accepts 16-bit signed samples through a valid/ready handshake and emits two filtered output samples per input, at twice the input rate. It uses the same 9-tap symmetric low-pass prototype as the team's decimation-side FIR, split into two polyphase branches, so a decimate/interpolate pair shares one coefficient set. It sits between the sample processing core and the DAC interface.

## Interface
- DATA_W, 16: input/output sample width, two's complement.
- COEF_W, 16: coefficient width, signed Q1.15.
- SHIFT, 14: right shift applied to each branch accumulator (per-branch unity gain is 2^14).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inData  in  DATA_W  input sample.
- inValid  in  1  inData valid.
- inReady  out  1  block can accept a sample this cycle.
- outData  out  DATA_W  interpolated output sample.
- outValid  out  1  outData valid.
- outReady  in  1  downstream accepts outData this cycle.

## Operation
- Prototype taps h[0..8] = 0x04F6, 0x0AE4, 0x1089, 0x1496, 0x160F, 0x1496, 0x1089, 0x0AE4, 0x04F6.
- Delay line x[0..4]. On accept (inValid && inReady): x[0] <= inData, x[k] <= x[k-1]. The oldest sample is dropped.
- Branch 0 (even output): acc0 = sum over k=0..4 of x[k]*h[2k].
- Branch 1 (odd output): acc1 = sum over k=0..3 of x[k]*h[2k+1].
- Both accumulators use full precision, at least 35 bits signed.
- Output conversion: acc >>> SHIFT as an arithmetic shift with truncation toward minus infinity (no rounding). The result then saturates to [-32768, 32767].
- For each accepted sample, the branch-0 output is emitted first, then the branch-1 output.
- FSM states:
  - IDLE: inReady=1. On accept, go to MUL.
  - MUL: register all 9 products from the updated delay line. Go to SUM.
  - SUM: register acc0 and acc1. Go to OUT0.
  - OUT0: outData = sat(acc0), outValid=1. When outReady, load sat(acc1) and go to OUT1. Otherwise hold.
  - OUT1: outValid=1. inReady = outReady.
    - outReady && inValid: accept the new sample and go to MUL.
    - outReady && !inValid: go to IDLE.
    - !outReady: hold.
- outData/outValid are registered and must stay stable while outValid && !outReady.
- inReady is 0 in MUL, SUM and OUT0. Input is never accepted while a result is pending.
- Reset values:
  - state IDLE.
  - x[0..4]=0, products and accumulators 0.
  - outData=0, outValid=0, inReady=1.
- Reset mid-operation discards any in-flight sample and output. The delay line is cleared.

## Timing
- Accept at cycle T produces outValid=1 with the branch-0 result at T+3. This holds from IDLE and from an OUT1 accept.
- With outReady held high, the branch-1 result appears at T+4.
- Maximum throughput is one input per 4 cycles, giving 2 outputs per 4 cycles. This requires the back-to-back accept in OUT1.
- Output backpressure stalls only OUT0/OUT1. The pipeline never drops or duplicates a sample.
- Reset deassertion is synchronized externally. The first accept is possible in the first clock after release.

## Structure
- Package fir_pkg holds:
  - DATA_W, COEF_W, ACC_W constants.
  - The 9-entry coefficient array. The decimation-side FIR is migrated to it so both filters share one coefficient set.
  - The state typedef: IDLE, MUL, SUM, OUT0, OUT1.
- One sub-module, fir_sat: parameterized arithmetic shift, truncation and saturation from ACC_W to DATA_W. It is instanced once per branch.
- Products are registered in one stage so each maps onto a DSP slice.

## Test plan
- Impulse: 0x4000 then six 0x0000 samples, with outReady=1. Required output sequence:
  - 0x04F6, 0x0AE4
  - 0x1089, 0x1496
  - 0x160F, 0x1496
  - 0x1089, 0x0AE4
  - 0x04F6, 0x0000
  - then zeros.
- Positive full scale: steady 0x7FFF with the line filled. Required outputs alternate 0x7FFF (branch 0 saturated) and 0x7DE7 (branch 1, 32231).
- Negative full scale: steady 0x8000 with the line filled. Required outputs alternate 0x8000 (saturated) and 0x8218 (-32232).
- Backpressure:
  - Hold outReady=0 for 10 cycles in OUT0. outData stays 0x04F6 and inReady stays 0.
  - Release outReady. Outputs resume in order with none lost.
- Back-to-back: inValid=1 and outReady=1 continuously. Required behaviour:
  - inReady pulses every 4th cycle.
  - outValid pattern is 1,1,0,0 after the first fill.
  - First output appears 3 cycles after the first accept.
- Reset mid-flight: assert rst_n=0 during SUM.
  - Immediately: outValid=0, outData=0, inReady=1.
  - A following impulse reproduces the impulse sequence exactly, showing the delay line was cleared.
